// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings, FSM states and size helper for the memory bus router
package mem_bus_pkg;

    localparam logic [2:0] BHW_BYTE = 3'b001;
    localparam logic [2:0] BHW_HALF = 3'b010;
    localparam logic [2:0] BHW_WORD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of bytes moved by one bus access; 0 flags an illegal size code.
    function automatic logic [2:0] bhw_to_count(input logic [2:0] bhw);
        case (bhw)
            BHW_BYTE: return 3'd1;
            BHW_HALF: return 3'd2;
            BHW_WORD: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - combinational base/mask address decoder with lowest-index priority
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int                      N_SLAVES   = 4,
    parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK = {N_SLAVES{32'h0}},
    parameter int                      IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [31:0]         addr,
    output logic [N_SLAVES-1:0] onehot,
    output logic [IDX_W-1:0]    idx,
    output logic                hit
);

    // Scan from the top index down so the lowest matching window overrides the rest.
    always_comb begin
        onehot = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int s = N_SLAVES - 1; s >= 0; s--) begin
            if ((addr & SLAVE_MASK[32*s +: 32]) == SLAVE_BASE[32*s +: 32]) begin
                onehot    = '0;
                onehot[s] = 1'b1;
                idx       = IDX_W'(s);
                hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - splits a CPU byte/half/word access into per-byte slave transactions
module mem_bus_router
    import mem_bus_pkg::*;
#(
    parameter int                      N_SLAVES       = 4,
    parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE     = {N_SLAVES{32'h0}},
    parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK     = {N_SLAVES{32'h0}},
    parameter int                      TIMEOUT_CYCLES = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_bus_DV,
    input  logic [31:0]             i_bus_address,
    input  logic [31:0]             i_bus_data,
    input  logic [2:0]              i_bhw,
    input  logic                    i_write_notread,
    output logic [31:0]             o_bus_data,
    output logic                    o_bus_DV,
    output logic                    o_bus_err,
    output logic                    o_busy,
    output logic [N_SLAVES-1:0]     o_sub_request,
    output logic [31:0]             o_sub_address,
    output logic [7:0]              o_sub_data,
    output logic                    o_sub_write,
    input  logic [8*N_SLAVES-1:0]   i_sub_data,
    input  logic [N_SLAVES-1:0]     i_sub_DV
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    // The timer holds the number of cycles since the request pulse, so DONE
    // lands exactly TIMEOUT_CYCLES cycles after the request of a silent slave.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;

    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          lanes_q;
    logic [2:0]           size_q;
    logic [1:0]           cnt_q;
    logic                 wr_q;
    logic                 err_q;
    logic [IDX_W-1:0]     sel_q;
    logic [TMR_W-1:0]     timer_q;

    logic [N_SLAVES-1:0]  dec_onehot;
    logic [IDX_W-1:0]     dec_idx;
    logic                 dec_hit;

    logic [2:0]           accept_count;
    logic                 sub_dv;
    logic [7:0]           sub_byte;
    logic                 last_byte;
    logic                 timed_out;

    mem_bus_decoder #(
        .N_SLAVES   (N_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .addr   (addr_q),
        .onehot (dec_onehot),
        .idx    (dec_idx),
        .hit    (dec_hit)
    );

    assign accept_count = bhw_to_count(i_bhw);
    assign sub_dv       = i_sub_DV[sel_q];
    assign sub_byte     = i_sub_data[{sel_q, 3'b000} +: 8];
    assign last_byte    = ({1'b0, cnt_q} == (size_q - 3'd1));
    assign timed_out    = (timer_q == TMR_LAST);

    assign o_bus_data    = lanes_q;
    assign o_sub_address = addr_q;
    assign o_sub_data    = wdata_q[{cnt_q, 3'b000} +: 8];
    assign o_sub_write   = wr_q;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; every error path funnels into DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_bus_DV) begin
                    state_d = (accept_count == 3'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = dec_hit ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (sub_dv) begin
                    state_d = last_byte ? ST_DONE : ST_ISSUE;
                end else if (timed_out) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs: request pulse, completion pulse and busy flag.
    always_comb begin
        o_sub_request = '0;
        o_bus_DV      = 1'b0;
        o_bus_err     = 1'b0;
        o_busy        = (state_q != ST_IDLE);
        if (state_q == ST_ISSUE && dec_hit) begin
            o_sub_request = dec_onehot;
        end
        if (state_q == ST_DONE) begin
            o_bus_DV  = 1'b1;
            o_bus_err = err_q;
        end
    end

    // Access registers, byte counter, timeout timer and read lanes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            lanes_q <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            timer_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_bus_DV) begin
                        addr_q  <= i_bus_address;
                        wdata_q <= i_bus_data;
                        size_q  <= accept_count;
                        wr_q    <= i_write_notread;
                        cnt_q   <= '0;
                        err_q   <= (accept_count == 3'd0);
                        lanes_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (dec_hit) begin
                        sel_q   <= dec_idx;
                        timer_q <= TMR_W'(1);
                    end else begin
                        err_q   <= 1'b1;
                        lanes_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (sub_dv) begin
                        if (!wr_q) begin
                            lanes_q[{cnt_q, 3'b000} +: 8] <= sub_byte;
                        end
                        if (!last_byte) begin
                            cnt_q  <= cnt_q + 2'd1;
                            addr_q <= addr_q + 32'd1;
                        end
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        lanes_q <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_router.sv
// tb/tb_mem_bus_router.sv - randomized self-checking bench for mem_bus_router with a behavioural model
module tb_mem_bus_router;

    localparam int NS  = 4;
    localparam int TMO = 8;

    typedef struct {
        int          slave;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        wr;
    } req_t;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_bus_DV;
    logic [31:0]       i_bus_address;
    logic [31:0]       i_bus_data;
    logic [2:0]        i_bhw;
    logic              i_write_notread;
    logic [31:0]       o_bus_data;
    logic              o_bus_DV;
    logic              o_bus_err;
    logic              o_busy;
    logic [NS-1:0]     o_sub_request;
    logic [31:0]       o_sub_address;
    logic [7:0]        o_sub_data;
    logic              o_sub_write;
    logic [8*NS-1:0]   i_sub_data;
    logic [NS-1:0]     i_sub_DV;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 1;
    bit   mute     = 1'b0;
    bit   noise    = 1'b0;
    req_t req_log[$];

    always #5 clk = ~clk;

    mem_bus_router #(
        .N_SLAVES       (NS),
        .SLAVE_BASE     ({32'h0000_0000, 32'hF000_0000, 32'h0000_1000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_bus_DV        (i_bus_DV),
        .i_bus_address   (i_bus_address),
        .i_bus_data      (i_bus_data),
        .i_bhw           (i_bhw),
        .i_write_notread (i_write_notread),
        .o_bus_data      (o_bus_data),
        .o_bus_DV        (o_bus_DV),
        .o_bus_err       (o_bus_err),
        .o_busy          (o_busy),
        .o_sub_request   (o_sub_request),
        .o_sub_address   (o_sub_address),
        .o_sub_data      (o_sub_data),
        .o_sub_write     (o_sub_write),
        .i_sub_data      (i_sub_data),
        .i_sub_DV        (i_sub_DV)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory map of the bench: slave 3 covers 0x0000-0xFFFF but loses to 0 and 1.
    function automatic int model_decode(input logic [31:0] a);
        if ((a & 32'hFFFF_F000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_F000) == 32'h0000_1000) return 1;
        if ((a & 32'hF000_0000) == 32'hF000_0000) return 2;
        if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 3;
        return -1;
    endfunction

    function automatic int model_count(input logic [2:0] bhw);
        if (bhw == 3'b001) return 1;
        if (bhw == 3'b010) return 2;
        if (bhw == 3'b100) return 4;
        return 0;
    endfunction

    function automatic logic [7:0] rd_byte(input int s, input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ (8'h5A + 8'(s) * 8'd37);
    endfunction

    // Slave farm: logs each request and answers after lat cycles unless muted.
    initial begin
        i_sub_DV   = '0;
        i_sub_data = '0;
        forever begin
            @(negedge clk);
            if (o_sub_request != '0) begin
                int   s;
                req_t r;
                check("req_onehot", 32'($countones(o_sub_request)), 32'd1);
                s = 0;
                for (int i = NS - 1; i >= 0; i--) if (o_sub_request[i]) s = i;
                r.slave = s;
                r.addr  = o_sub_address;
                r.data  = o_sub_data;
                r.wr    = o_sub_write;
                req_log.push_back(r);
                if (!mute) begin
                    for (int t = 1; t <= lat; t++) begin
                        @(posedge clk);
                        #1;
                        i_sub_DV   = '0;
                        i_sub_data = '0;
                        if (t == lat) begin
                            i_sub_DV[s]          = 1'b1;
                            i_sub_data[8*s +: 8] = rd_byte(s, r.addr);
                        end else if (noise && t == 1) begin
                            i_sub_DV[(s+1)%NS]          = 1'b1;
                            i_sub_data[8*((s+1)%NS) +: 8] = 8'hEE;
                        end
                    end
                    @(posedge clk);
                    #1;
                    i_sub_DV   = '0;
                    i_sub_data = '0;
                end
            end
        end
    end

    task automatic run_access(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] bhw,
                              input logic wr, input int l, input bit m, input bit nz, input bit poke);
        req_t        exp_q[$];
        req_t        e;
        int          cnt;
        int          exp_cyc;
        bit          exp_err;
        logic [31:0] exp_data;
        int          cyc;
        bit          seen;
        logic [31:0] a;
        int          s;

        cnt      = model_count(bhw);
        exp_err  = 1'b0;
        exp_data = '0;
        exp_cyc  = 1;
        if (cnt == 0) exp_err = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            a = addr + 32'(k);
            s = model_decode(a);
            if (s < 0) begin
                exp_err = 1'b1;
                exp_cyc += 1;
                break;
            end
            e.slave = s;
            e.addr  = a;
            e.data  = data[8*k +: 8];
            e.wr    = wr;
            exp_q.push_back(e);
            if (m) begin
                exp_err = 1'b1;
                exp_cyc += TMO;
                break;
            end
            exp_cyc += 1 + l;
            if (!wr) exp_data[8*k +: 8] = rd_byte(s, a);
        end
        if (exp_err || wr) exp_data = '0;

        @(negedge clk);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        req_log.delete();
        lat             = l;
        mute            = m;
        noise           = nz;
        i_bus_address   = addr;
        i_bus_data      = data;
        i_bhw           = bhw;
        i_write_notread = wr;
        i_bus_DV        = 1'b1;
        @(posedge clk);
        #1;
        i_bus_DV        = 1'b0;
        i_bus_data      = $urandom;
        i_bus_address   = $urandom;

        cyc  = 0;
        seen = 1'b0;
        while (cyc < 64 && !seen) begin
            @(negedge clk);
            cyc++;
            if (o_bus_DV) begin
                seen     = 1'b1;
                i_bus_DV = 1'b0;
            end else if (poke && cyc == 2) begin
                i_bus_DV      = 1'b1;
                i_bus_address = 32'h0000_1500;
                i_bhw         = 3'b001;
            end else begin
                i_bus_DV = 1'b0;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("done_cycle", 32'(cyc), 32'(exp_cyc));
            check("done_err", {31'd0, o_bus_err}, {31'd0, exp_err});
            check("done_data", o_bus_data, exp_data);
            check("done_busy", {31'd0, o_busy}, 32'd1);
        end
        @(negedge clk);
        check("after_dv", {31'd0, o_bus_DV}, 32'd0);
        check("after_busy", {31'd0, o_busy}, 32'd0);
        check("after_data", o_bus_data, exp_data);
        check("req_count", 32'(req_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
            check("req_slave", 32'(req_log[i].slave), 32'(exp_q[i].slave));
            check("req_addr", req_log[i].addr, exp_q[i].addr);
            check("req_wr", {31'd0, req_log[i].wr}, {31'd0, exp_q[i].wr});
            if (wr) check("req_data", {24'd0, req_log[i].data}, {24'd0, exp_q[i].data});
        end
        mute  = 1'b0;
        noise = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rb;
        bit          bad;

        i_rst           = 1'b1;
        i_bus_DV        = 1'b0;
        i_bus_address   = '0;
        i_bus_data      = '0;
        i_bhw           = 3'b001;
        i_write_notread = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dv", {31'd0, o_bus_DV}, 32'd0);
        check("rst_err", {31'd0, o_bus_err}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_data", o_bus_data, 32'd0);
        check("rst_req", {28'd0, o_sub_request}, 32'd0);
        check("rst_addr", o_sub_address, 32'd0);
        i_rst = 1'b0;

        run_access(32'h0000_0100, 32'h1122_3344, 3'b100, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        run_access(32'h0000_0FFF, 32'h0, 3'b010, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        run_access(32'hDEAD_0000, 32'h0, 3'b001, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        run_access(32'h0000_1234, 32'h0, 3'b001, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        run_access(32'h0000_1234, 32'h0, 3'b001, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        run_access(32'h0000_0200, 32'h0, 3'b011, 1'b0, 1, 1'b0, 1'b0, 1'b1);
        run_access(32'hFFFF_FFFE, 32'h0, 3'b100, 1'b0, 2, 1'b0, 1'b1, 1'b1);
        run_access(32'h0000_FFFE, 32'hA1B2_C3D4, 3'b100, 1'b1, 1, 1'b0, 1'b0, 1'b0);

        // Reset in the wait phase of the third byte of a word read.
        @(negedge clk);
        req_log.delete();
        lat             = 3;
        i_bus_address   = 32'h0000_0200;
        i_bhw           = 3'b100;
        i_write_notread = 1'b0;
        i_bus_DV        = 1'b1;
        @(posedge clk);
        #1;
        i_bus_DV = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_reqs", 32'(req_log.size()), 32'd3);
        i_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_dv", {31'd0, o_bus_DV}, 32'd0);
        check("mid_rst_err", {31'd0, o_bus_err}, 32'd0);
        check("mid_rst_data", o_bus_data, 32'd0);
        check("mid_rst_req", {28'd0, o_sub_request}, 32'd0);
        check("mid_rst_addr", o_sub_address, 32'd0);
        check("mid_rst_sdata", {24'd0, o_sub_data}, 32'd0);
        check("mid_rst_wr", {31'd0, o_sub_write}, 32'd0);
        i_rst = 1'b0;
        bad   = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (o_bus_DV || o_busy) bad = 1'b1;
        end
        check("post_rst_quiet", {31'd0, bad}, 32'd0);
        check("post_rst_reqs", 32'(req_log.size()), 32'd3);
        run_access(32'h0000_0300, 32'h0, 3'b100, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 6))
                0:       ra = 32'h0000_0FF8 + 32'($urandom_range(0, 15));
                1:       ra = 32'h0000_1FF8 + 32'($urandom_range(0, 15));
                2:       ra = 32'h0000_2000 + 32'($urandom_range(0, 32'hDFF0));
                3:       ra = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                4:       ra = 32'hF000_0000 | 32'($urandom);
                5:       ra = 32'h4000_0000 + 32'($urandom_range(0, 4095));
                default: ra = 32'h0000_FFFC + 32'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 7))
                0, 1:    rb = 3'b001;
                2, 3:    rb = 3'b010;
                4, 5:    rb = 3'b100;
                6:       rb = 3'b011;
                default: rb = 3'b111;
            endcase
            run_access(ra, $urandom, rb, 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                       ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
